// File: rtl/datapath_sequencer.sv
// datapath_sequencer: issue controller for the register-file/ALU datapath.
// Accepts 48-bit micro-instructions (plus an optional 32-bit constant beat)
// over valid/ready and presents them to the datapath rpt+1 times each.
// Optional feature: define DP_SEQ_AUTOINC_EN to add the iteration number to
// the A/B/C/D/Y1/Y2 register indices on repeat iterations (mod 16).
module datapath_sequencer #(
  parameter int IW = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          hold,
  output logic [2:0]    op,
  output logic          form,
  output logic [1:0]    vec,
  output logic [3:0]    A,
  output logic [3:0]    B,
  output logic [3:0]    C,
  output logic [3:0]    D,
  output logic [3:0]    Y1,
  output logic [3:0]    Y2,
  output logic [3:0]    zero_reg,
  output logic [1:0]    write,
  output logic          const_a,
  output logic [31:0]   constant,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_CONST = 2'd1,
    S_ISSUE      = 2'd2
  } state_t;

  // Control fields of one instruction; idx[0]=A .. idx[5]=Y2.
  typedef struct packed {
    logic [2:0]      op;
    logic            form;
    logic [1:0]      vec;
    logic [5:0][3:0] idx;
    logic [3:0]      zero_reg;
    logic [1:0]      wr;
    logic            ca;
  } ctl_t;

  function automatic ctl_t decode(input logic [47:0] b);
    ctl_t c;
    c.op       = b[2:0];
    c.form     = b[3];
    c.vec      = b[5:4];
    c.idx      = b[29:6];
    c.zero_reg = b[33:30];
    c.wr       = b[35:34];
    c.ca       = b[36];
    return c;
  endfunction

  state_t          state_q, state_d;
  ctl_t            fld_q, fld_d;    // latched instruction fields
  ctl_t            out_q, out_d;    // values currently driven to the datapath
  logic [7:0]      rpt_q, rpt_d;
  logic [7:0]      iter_q, iter_d;
  logic [31:0]     const_q, const_d;
  logic            err_q, err_d;
  logic            busy_q;

  ctl_t            ins;
  logic            resv;
  logic            last;
  logic            accept;
  logic            load;
  logic [5:0][3:0] idx_inc;

  assign ins    = decode(in_data[47:0]);
  assign resv   = |in_data[47:45];
  assign last   = (state_q == S_ISSUE) && (iter_q == rpt_q);
  // Reset forces ready low; hold always stalls the input side.
  assign in_ready = rst_n && !hold && ((state_q != S_ISSUE) || last);
  assign accept   = in_valid && in_ready;

  // Next-state, iteration and field-latch decisions.
  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    rpt_d   = rpt_q;
    iter_d  = iter_q;
    const_d = const_q;
    err_d   = err_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) load = 1'b1;
      end
      S_WAIT_CONST: begin
        if (accept) begin
          const_d = in_data[31:0];
          state_d = S_ISSUE;
          iter_d  = '0;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          if (!last)       iter_d  = iter_q + 8'd1;
          else if (accept) load    = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      fld_d  = ins;
      iter_d = '0;
      if (resv) begin
        // Malformed instruction: flag it and issue once without writing.
        err_d    = 1'b1;
        fld_d.wr = 2'b00;
        fld_d.ca = 1'b0;
        rpt_d    = '0;
        state_d  = S_ISSUE;
      end else begin
        rpt_d   = in_data[44:37];
        state_d = ins.ca ? S_WAIT_CONST : S_ISSUE;
      end
    end
  end

  // Per-index iteration offset applied to the presented register indices.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_idx
`ifdef DP_SEQ_AUTOINC_EN
      assign idx_inc[gi] = fld_d.idx[gi] + iter_d[3:0];
`else
      assign idx_inc[gi] = fld_d.idx[gi];
`endif
    end
  endgenerate

  // Outputs only change when an iteration is about to be presented.
  always_comb begin
    out_d = out_q;
    if (state_d == S_ISSUE) begin
      out_d     = fld_d;
      out_d.idx = idx_inc;
    end
  end

  // State and registered datapath controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fld_q   <= '0;
      out_q   <= '0;
      rpt_q   <= '0;
      iter_q  <= '0;
      const_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      out_q   <= out_d;
      rpt_q   <= rpt_d;
      iter_q  <= iter_d;
      const_q <= const_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign op       = out_q.op;
  assign form     = out_q.form;
  assign vec      = out_q.vec;
  assign A        = out_q.idx[0];
  assign B        = out_q.idx[1];
  assign C        = out_q.idx[2];
  assign D        = out_q.idx[3];
  assign Y1       = out_q.idx[4];
  assign Y2       = out_q.idx[5];
  assign zero_reg = out_q.zero_reg;
  assign const_a  = out_q.ca;
  assign constant = const_q;
  assign busy     = busy_q;
  assign err      = err_q;
  // Write strobe is gated combinationally so a stall takes effect immediately.
  assign write    = ((state_q == S_ISSUE) && !hold) ? out_q.wr : 2'b00;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: directed scenarios plus a randomized
// instruction stream checked against a per-iteration scoreboard.
module tb_datapath_sequencer;

`ifdef DP_SEQ_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        hold;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D, Y1, Y2, zero_reg;
  logic [1:0]  write;
  logic        const_a;
  logic [31:0] constant;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(.IW(48)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .hold(hold), .op(op), .form(form), .vec(vec),
    .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2), .zero_reg(zero_reg),
    .write(write), .const_a(const_a), .constant(constant),
    .busy(busy), .err(err)
  );

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [2:0] o, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] y1,
                                     input logic [1:0] wr, input logic ca,
                                     input logic [7:0] rpt);
    logic [47:0] r;
    r = '0;
    r[2:0]   = o;
    r[9:6]   = a;
    r[13:10] = b;
    r[25:22] = y1;
    r[35:34] = wr;
    r[36]    = ca;
    r[44:37] = rpt;
    return r;
  endfunction

  // What the datapath should see on iteration n of instruction b with constant k.
  function automatic logic [71:0] exp_pack(input logic [47:0] b, input int n, input logic [31:0] k);
    logic [5:0][3:0] idx;
    int inc;
    inc = AUTOINC ? n : 0;
    for (int i = 0; i < 6; i++) idx[i] = 4'((int'(b[6+4*i +: 4]) + inc) % 16);
    return {3'b000, b[2:0], b[3], b[5:4], idx, b[33:30], b[35:34], b[36], k};
  endfunction

  function automatic logic [71:0] obs_pack();
    return {3'b000, op, form, vec, Y2, Y1, D, C, B, A, zero_reg, write, const_a, constant};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [47:0] beat;
    int          n;
    logic [31:0] k;
  } exp_t;

  exp_t        expq[$];
  logic [47:0] beats[$];

  initial begin
    logic [47:0] i1, i2, i3, i4, i6, i7, i8;
    logic [47:0] strm[3];
    int          wcnt, nexp;
    logic [31:0] last_k;
    exp_t        e;

    rst_n = 1'b0; in_valid = 1'b1; hold = 1'b0; in_data = 48'h1;
    @(negedge clk);
    check_eq("reset_outputs", obs_pack(), 72'h0);
    check_eq("reset_ready", in_ready, 0);
    check_eq("reset_busy_err", {busy, err}, 0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Single instruction, rpt=0
    i1 = mk(3'd3, 4'd1, 4'd2, 4'd5, 2'b01, 1'b0, 8'd0);
    in_valid = 1'b1; in_data = i1;
    @(negedge clk);
    check_eq("t1_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_issue", obs_pack(), exp_pack(i1, 0, 32'h0));
    check_eq("t1_busy", busy, 1);
    tick();
    @(negedge clk);
    check_eq("t1_idle_wr_busy", {write, busy}, 0);

    // Instruction with trailing constant, two cycles apart
    i2 = mk(3'd5, 4'd0, 4'd9, 4'd7, 2'b01, 1'b1, 8'd0);
    tick(); in_valid = 1'b1; in_data = i2;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_wait_wr", write, 0);
    check_eq("t2_wait_busy", busy, 1);
    tick();
    @(negedge clk);
    check_eq("t2_wait_wr2", write, 0);
    in_valid = 1'b1; in_data = 48'hE000_DEAD_BEEF;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_issue", obs_pack(), exp_pack(i2, 0, 32'hDEADBEEF));
    check_eq("t2_no_err", err, 0);
    tick();
    @(negedge clk);
    check_eq("t2_done_wr", write, 0);

    // Repeat 3 with Y1=14
    i3 = mk(3'd1, 4'd4, 4'd8, 4'd14, 2'b11, 1'b0, 8'd3);
    in_valid = 1'b1; in_data = i3;
    tick(); in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_eq($sformatf("t3_iter%0d", n), obs_pack(), exp_pack(i3, n, 32'hDEADBEEF));
      tick();
    end
    @(negedge clk);
    check_eq("t3_after_wr", write, 0);

    // rpt=2 with a two-cycle hold during iteration 1
    i4 = mk(3'd6, 4'd15, 4'd3, 4'd11, 2'b01, 1'b0, 8'd2);
    in_valid = 1'b1; in_data = i4;
    tick(); in_valid = 1'b0;
    wcnt = 0; nexp = 0;
    for (int c = 0; c < 8; c++) begin
      hold = (c == 1 || c == 2);
      @(negedge clk);
      if (hold) check_eq("t4_hold_wr", write, 0);
      else if (write != 2'b00) begin
        check_eq($sformatf("t4_iter%0d", nexp), obs_pack(), exp_pack(i4, nexp, 32'hDEADBEEF));
        nexp++;
      end
      if (write != 2'b00) wcnt++;
      tick();
    end
    hold = 1'b0;
    check_eq("t4_write_count", wcnt, 3);

    // Three back-to-back rpt=0 instructions
    for (int i = 0; i < 3; i++)
      strm[i] = mk(3'(i + 2), 4'(i), 4'(i + 5), 4'(i + 9), 2'b10, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = strm[i];
      @(negedge clk);
      check_eq($sformatf("t5_ready%0d", i), in_ready, 1);
      if (i > 0) check_eq($sformatf("t5_issue%0d", i - 1), obs_pack(), exp_pack(strm[i-1], 0, 32'hDEADBEEF));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_issue2", obs_pack(), exp_pack(strm[2], 0, 32'hDEADBEEF));
    tick();
    @(negedge clk);
    check_eq("t5_idle_wr", write, 0);

    // Reserved bit set, rpt=5
    i6 = mk(3'd2, 4'd1, 4'd1, 4'd1, 2'b11, 1'b0, 8'd5);
    i6[46] = 1'b1;
    in_valid = 1'b1; in_data = i6;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_err_wr_busy", {err, write, busy}, {1'b1, 2'b00, 1'b1});
    tick();
    @(negedge clk);
    check_eq("t6_once", {err, busy}, {1'b1, 1'b0});
    tick(); tick(); tick();
    @(negedge clk);
    check_eq("t6_sticky", err, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_err_cleared", err, 0);
    tick();
    rst_n = 1'b1;

    // Reset in the middle of a long repeat
    i7 = mk(3'd7, 4'd2, 4'd3, 4'd4, 2'b10, 1'b0, 8'd10);
    in_valid = 1'b1; in_data = i7;
    tick(); in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_eq($sformatf("t7_iter%0d", n), obs_pack(), exp_pack(i7, n, 32'h0));
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_eq("t7_abort_outputs", obs_pack(), 72'h0);
    check_eq("t7_abort_busy_ready", {busy, in_ready}, 0);
    tick();
    rst_n = 1'b1;
    i8 = mk(3'd4, 4'd6, 4'd7, 4'd8, 2'b01, 1'b0, 8'd0);
    in_valid = 1'b1; in_data = i8;
    @(negedge clk);
    check_eq("t7_ready_after", in_ready, 1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("t7_new_issue", obs_pack(), exp_pack(i8, 0, 32'h0));
    tick();
    @(negedge clk);

    // Randomized stream with random valid gaps and holds
    last_k = 32'h0;
    for (int t = 0; t < 40; t++) begin
      logic [63:0] r;
      logic [1:0]  wr;
      logic        ca;
      logic [7:0]  rpt;
      logic [47:0] b;
      r   = {$urandom, $urandom};
      wr  = 2'($urandom_range(1, 3));
      ca  = ($urandom_range(0, 3) == 0);
      rpt = 8'($urandom_range(0, 4));
      b   = {3'b000, rpt, ca, wr, r[33:0]};
      beats.push_back(b);
      if (ca) begin
        last_k = $urandom;
        beats.push_back({r[63:48], last_k});
      end
      for (int n = 0; n <= int'(rpt); n++) begin
        e.beat = b; e.n = n; e.k = last_k;
        expq.push_back(e);
      end
    end
    tick();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      hold     = ($urandom_range(0, 4) == 0);
      in_valid = (beats.size() > 0) && ($urandom_range(0, 3) != 0);
      in_data  = in_valid ? beats[0] : {16'($urandom), $urandom};
      @(negedge clk);
      if (hold) check_eq("rnd_hold_wr", write, 0);
      if (write != 2'b00) begin
        if (expq.size() == 0) check_eq("rnd_spurious_wr", write, 0);
        else begin
          e = expq.pop_front();
          check_eq($sformatf("rnd_iter%0d", e.n), obs_pack(), exp_pack(e.beat, e.n, e.k));
        end
      end
      if (in_valid && in_ready) begin
        $display("beat accepted cyc=%0d data=%h", cyc, beats[0]);
        void'(beats.pop_front());
      end
      tick();
      if (beats.size() == 0 && expq.size() == 0) break;
    end
    hold = 1'b0; in_valid = 1'b0;
    check_eq("rnd_beats_drained", beats.size(), 0);
    check_eq("rnd_iters_drained", expq.size(), 0);
    tick(); tick();
    @(negedge clk);
    check_eq("rnd_final_idle", {busy, write}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Issue controller for the register-file/ALU datapath. Accepts 48-bit micro-instructions over a valid/ready handshake, optionally absorbs a trailing 32-bit constant beat, and drives the datapath's control inputs one registered cycle later, repeating each instruction a programmable number of times. It sits between the instruction source and the datapath's `op/form/vec/A/B/C/D/Y1/Y2/zero_reg/write/const_a/constant` inputs.

## Interface
- `IW`, 48, instruction/beat width; must be ≥ 48.
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: beat on `in_data` is valid.
- `in_ready` output 1: sequencer accepts the beat this cycle.
- `in_data` input IW: instruction beat, or constant beat in bits [31:0].
- `hold` input 1: external stall.
- `op` output 3, `form` output 1, `vec` output 2: ALU controls.
- `A`, `B`, `C`, `D`, `Y1`, `Y2` output 4 each: register indices.
- `zero_reg` output 4, `write` output 2, `const_a` output 1, `constant` output 32: datapath controls.
- `busy` output 1: state ≠ IDLE.
- `err` output 1: sticky reserved-field error.

## Operation
- Instruction fields: [2:0] op, [3] form, [5:4] vec, [9:6] A, [13:10] B, [17:14] C, [21:18] D, [25:22] Y1, [29:26] Y2, [33:30] zero_reg, [35:34] write, [36] const_a, [44:37] rpt, [47:45] reserved.
- Handshake: a beat transfers at a rising edge with `in_valid && in_ready`. `in_ready` is combinational:
  - `!hold` and state is IDLE or WAIT_CONST, or
  - state is ISSUE on its final iteration.
- FSM:
  - IDLE: on an instruction beat with const_a=0, go to ISSUE. With const_a=1, latch the fields and go to WAIT_CONST.
  - WAIT_CONST: the next accepted beat's [31:0] loads `constant`; go to ISSUE. Its upper bits are ignored, and no error is raised.
  - ISSUE: presents the instruction for rpt+1 cycles, with `write` = the field value each cycle.
    - On the final iteration, an accepted instruction beat chains directly: ISSUE again, or WAIT_CONST if const_a=1.
    - Otherwise the next state is IDLE.
- Outside ISSUE, `write` is 00. All other control outputs keep their last values.
- `constant` holds its value until the next constant beat.
- Reserved bits nonzero: set `err` (cleared only by reset). The instruction issues exactly once with `write`=00, ignoring rpt and const_a.
- `hold`=1:
  - `write` is forced to 00 and `in_ready`=0.
  - The iteration counter, state and latched fields freeze.
  - The same iteration is re-presented after `hold` drops, so none is lost or duplicated.
- Reset values: all control outputs 0, `constant`=0, `busy`=0, `err`=0, state IDLE. `in_ready`=0 while `rst_n`=0.
- Reset asserted mid-ISSUE or in WAIT_CONST aborts immediately. Remaining iterations and any pending constant are discarded.

## Timing
- Latency: beat accepted at edge k (const_a=0) → iteration 0 presented in cycle k→k+1. The datapath writes it at edge k+1.
- With a constant: instruction at edge k, constant at edge j ≥ k+1 → issue begins after edge j.
- An instruction with rpt=R occupies exactly R+1 non-held ISSUE cycles.
- Back-to-back const_a=0 instructions with rpt=0 issue on consecutive cycles, with no bubble.
- A chained const_a=1 instruction inserts at least one `write`=00 cycle (WAIT_CONST).
- `busy` is registered with the state. `hold` takes effect in the same cycle it is sampled high (`write` is combinationally gated).

## Configuration
- `DP_SEQ_AUTOINC_EN` defined:
  - On each repeat iteration n>0, A, B, C, D, Y1 and Y2 equal their field value + n, mod 16 (wrap 15→0).
  - zero_reg, write and const_a stay constant.
- Undefined: all iterations present identical indices. The increment logic is absent.

## Test plan
- Reset, then `in_data` = op=3, A=1, B=2, Y1=5, write=01, rpt=0 with `in_valid` at edge 1 → exactly one cycle with write=01, Y1=5, op=3, then IDLE. `busy` falls after edge 2.
- Instruction const_a=1, A=0, write=01, rpt=0, followed two cycles later by a constant beat 0xDEADBEEF → WAIT_CONST holds write=00. A single issue cycle follows with const_a=1 and constant=0xDEADBEEF.
- rpt=3, Y1=14, write=11 → four write cycles.
  - With `DP_SEQ_AUTOINC_EN`: Y1 = 14, 15, 0, 1.
  - Without it: Y1 = 14 ×4.
- rpt=2 with `hold` high for 2 cycles during iteration 1 → exactly 3 write-asserted cycles total, and write=00 during the hold.
- Three rpt=0 instructions streamed continuously → three consecutive write cycles, `in_ready` stays 1.
- Instruction with bit 46 set and rpt=5 → `err`=1, one issue cycle with write=00. `err` persists until `rst_n` pulses low.
- Reset asserted mid-ISSUE of rpt=10 → outputs zero immediately. After release, a new instruction issues normally.
